// File: rtl/unsigned_radix_divider_pkg.sv
// rtl/unsigned_radix_divider_pkg.sv - shared types and sizing helpers for the radix divider
package unsigned_radix_divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } divider_state_t;

    // Width of the iteration counter and of the CLZ inputs.
    function automatic int div_count_w(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/unsigned_radix_divider_if.sv
// rtl/unsigned_radix_divider_if.sv - requester/divider handshake and operand bundle
// master: requester side (drives start, operands, abort; receives ready, done, results)
// slave : divider side
interface unsigned_radix_divider_if #(
    parameter int DATA_WIDTH = 32
);
    import unsigned_radix_divider_pkg::*;

    localparam int CLZ_W = div_count_w(DATA_WIDTH);

    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [CLZ_W-1:0]      dividend_CLZ;
    logic [DATA_WIDTH-1:0] divisor;
    logic [CLZ_W-1:0]      divisor_CLZ;
    logic                  divisor_is_zero;
    logic                  abort;
    logic                  ready;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;

    modport master (
        output start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero, abort,
        input  ready, done, quotient, remainder
    );

    modport slave (
        input  start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero, abort,
        output ready, done, quotient, remainder
    );

endinterface

// File: rtl/unsigned_radix_divider_radix_digit_select.sv
// rtl/unsigned_radix_divider_radix_digit_select.sv - one quotient digit and partial remainder per call
// rem_i   : current partial remainder
// d_i     : aligned divisor for this digit position
// digit_o : largest k with k*d_i <= rem_i
// rem_o   : rem_i - digit_o*d_i
module radix_digit_select #(
    parameter int DATA_WIDTH = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic [DATA_WIDTH-1:0]            rem_i,
    input  logic [DATA_WIDTH+RADIX_BITS-2:0] d_i,
    output logic [RADIX_BITS-1:0]            digit_o,
    output logic [DATA_WIDTH-1:0]            rem_o
);

    localparam int DW  = DATA_WIDTH + RADIX_BITS - 1;
    localparam int XW  = DW + RADIX_BITS;
    localparam int NUM = (1 << RADIX_BITS) - 1;

    logic [XW-1:0] mult [1:NUM];
    logic [XW-1:0] sel;

    always_comb begin
        // Multiples built by shift (even) and add (odd) so no multiplier is inferred.
        for (int j = 1; j <= NUM; j++) begin
            if (j == 1) begin
                mult[j] = XW'(d_i);
            end else if ((j % 2) == 0) begin
                mult[j] = mult[j/2] << 1;
            end else begin
                mult[j] = mult[j-1] + mult[1];
            end
        end

        // Multiples rise with j, so the last passing compare is the largest digit.
        digit_o = '0;
        sel     = '0;
        for (int j = 1; j <= NUM; j++) begin
            if (mult[j] <= XW'(rem_i)) begin
                digit_o = RADIX_BITS'(j);
                sel     = mult[j];
            end
        end

        rem_o = DATA_WIDTH'(XW'(rem_i) - sel);
    end

endmodule

// File: rtl/unsigned_radix_divider.sv
// rtl/unsigned_radix_divider.sv - iterative unsigned divider retiring RADIX_BITS quotient bits per cycle
// clk    : clock
// rst    : asynchronous active-high reset
// div_if : slave side of the requester handshake (start/abort/operands in, ready/done/results out)
module unsigned_radix_divider
    import unsigned_radix_divider_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    unsigned_radix_divider_if.slave   div_if
);

    localparam int DIV_COUNT_W = div_count_w(DATA_WIDTH);
    localparam int DW          = DATA_WIDTH + RADIX_BITS - 1;
    // Dividing by RADIX_BITS (1 or 2) is a shift by 0 or 1.
    localparam int RSH         = (RADIX_BITS == 2) ? 1 : 0;

    divider_state_t         state_q, state_d;
    logic [DIV_COUNT_W-1:0] count_q, count_d;
    logic [DW-1:0]          d_q, d_d;
    logic [DATA_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0]  q_q, q_d;

    logic [RADIX_BITS-1:0]  digit;
    logic [DATA_WIDTH-1:0]  rem_next;
    logic                   accept;
    logic [DIV_COUNT_W-1:0] shift;
    logic [DIV_COUNT_W-1:0] iters;

    radix_digit_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_digit (
        .rem_i   (rem_q),
        .d_i     (d_q),
        .digit_o (digit),
        .rem_o   (rem_next)
    );

    assign div_if.ready     = (state_q != DIVIDE);
    assign div_if.done      = (state_q == DONE);
    assign div_if.quotient  = q_q;
    assign div_if.remainder = rem_q;

    assign accept = div_if.start && (state_q != DIVIDE) && !div_if.abort;

    // Only meaningful on the normal path, where divisor_CLZ >= dividend_CLZ.
    // iters = C-1 = floor(shift / RADIX_BITS); initial alignment is iters*RADIX_BITS.
    assign shift = div_if.divisor_CLZ - div_if.dividend_CLZ;
    assign iters = shift >> RSH;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_d     = d_q;
        rem_d   = rem_q;
        q_d     = q_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    rem_d = div_if.dividend;
                    if (div_if.divisor_is_zero) begin
                        q_d     = '1;
                        state_d = DONE;
                    end else if (div_if.divisor_CLZ < div_if.dividend_CLZ) begin
                        q_d     = '0;
                        state_d = DONE;
                    end else begin
                        q_d     = '0;
                        count_d = iters;
                        d_d     = DW'(div_if.divisor) << (iters << RSH);
                        state_d = DIVIDE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                rem_d = rem_next;
                q_d   = (q_q << RADIX_BITS) | DATA_WIDTH'(digit);
                d_d   = d_q >> RADIX_BITS;
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - DIV_COUNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins from any state; a DONE result is already visible this cycle.
        if (div_if.abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
        end
    end

endmodule
